// File: rtl/if_id_fetch_buffer_pkg.sv
// Shared types and constants for the IF->ID fetch buffer.
// Default widths here match the module parameter defaults.
package project_types;

    localparam int PC_W_DEF   = 32;
    localparam int INST_W_DEF = 32;

    typedef logic [PC_W_DEF-1:0]   pc_t;
    typedef logic [INST_W_DEF-1:0] inst_t;

    typedef struct packed {
        pc_t   pc;
        inst_t inst;
    } fetch_entry_t;

    localparam inst_t INST_NOP = '0;

endpackage

// File: rtl/if_id_fetch_buffer_fifo.sv
// Small FIFO of fetched {pc, inst} entries.
// The head is read combinationally so that ID can load it on the same edge as the pop.
module fetch_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic [CNT_W-1:0]  count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign count_o = cnt_q;
    assign head_o  = mem[rd_q];

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign do_push = push_i & ~clear_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~clear_i & (cnt_q != '0);

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_pop)
                rd_d = (rd_q == LAST_PTR) ? '0 : rd_q + 1'b1;
            if (do_push)
                wr_d = (wr_q == LAST_PTR) ? '0 : wr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_q] <= data_i;
    end

endmodule

// File: rtl/if_id_fetch_buffer.sv
// IF->ID pipeline boundary: buffers fetched instructions while ID is stalled
// and drives the registered ID-stage instruction.
module if_id_fetch_buffer
    import project_types::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INST_W  = INST_W_DEF,
    parameter int DEPTH   = 4,
    parameter int STALL_W = 6,
    parameter int IF_IDX  = 1,
    parameter int ID_IDX  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [STALL_W-1:0]         stall,
    input  logic                       flush,
    input  logic                       if_valid_i,
    input  logic [PC_W-1:0]            if_pc_i,
    input  logic [INST_W-1:0]          if_inst_i,
    output logic                       id_valid_o,
    output logic [PC_W-1:0]            id_pc_o,
    output logic [INST_W-1:0]          id_inst_o,
    output logic                       stallreq_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o
);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int DATA_W = PC_W + INST_W;
    localparam logic [INST_W-1:0] NOP = INST_W'(INST_NOP);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    logic              id_adv;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic              bypass;
    logic              enq_req;
    logic              enq_ok;
    logic [DATA_W-1:0] head;
    logic [PC_W-1:0]   head_pc;
    logic [INST_W-1:0] head_inst;
    logic [CNT_W-1:0]  fifo_cnt;

    logic              valid_q, valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              ovf_q, ovf_d;

    // Only the IF and ID stall bits matter here.
    logic unused_stall;
    assign unused_stall = ^stall;

    assign id_adv     = ~stall[ID_IDX];
    assign push       = if_valid_i & ~stall[IF_IDX];
    assign fifo_empty = (fifo_cnt == '0);
    assign pop        = id_adv & ~fifo_empty;
    // Bypass only when nothing older is queued, so program order holds.
    assign bypass     = id_adv & fifo_empty & push;
    assign enq_req    = push & ~bypass;
    assign enq_ok     = enq_req & (~fifo_full | pop);
    assign {head_pc, head_inst} = head;

    fetch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .push_i  (enq_ok),
        .pop_i   (pop),
        .data_i  ({if_pc_i, if_inst_i}),
        .head_o  (head),
        .full_o  (fifo_full),
        .count_o (fifo_cnt)
    );

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        ovf_d   = ovf_q;
        if (flush) begin
            valid_d = 1'b0;
            pc_d    = '0;
            inst_d  = NOP;
        end else begin
            if (id_adv) begin
                if (!fifo_empty) begin
                    valid_d = 1'b1;
                    pc_d    = head_pc;
                    inst_d  = head_inst;
                end else if (push) begin
                    valid_d = 1'b1;
                    pc_d    = if_pc_i;
                    inst_d  = if_inst_i;
                end else begin
                    valid_d = 1'b0;
                    pc_d    = '0;
                    inst_d  = NOP;
                end
            end
            if (enq_req && !enq_ok)
                ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= NOP;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            ovf_q   <= ovf_d;
        end
    end

    assign id_valid_o = valid_q;
    assign id_pc_o    = pc_q;
    assign id_inst_o  = inst_q;
    assign overflow_o = ovf_q;
    assign count_o    = fifo_cnt;
    assign stallreq_o = (fifo_cnt == FULL_CNT) & stall[ID_IDX];

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// Directed bench for the IF->ID fetch buffer with hand-computed expectations.
module tb_if_id_fetch_buffer;

    localparam logic [5:0] ST_NONE = 6'b000000;
    localparam logic [5:0] ST_IF   = 6'b000010;
    localparam logic [5:0] ST_ID   = 6'b000100;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        if_valid_i;
    logic [31:0] if_pc_i;
    logic [31:0] if_inst_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        stallreq_o;
    logic [2:0]  count_o;
    logic        overflow_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_id_fetch_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .if_valid_i (if_valid_i),
        .if_pc_i    (if_pc_i),
        .if_inst_i  (if_inst_i),
        .id_valid_o (id_valid_o),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .stallreq_o (stallreq_o),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        if_valid_i = v;
        if_pc_i    = pc;
        if_inst_i  = pc ^ 32'hA5A5_0000;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = ST_NONE; flush = 1'b0; drive(1'b0, 32'h0);
        tick(); tick();
        checks += 4;
        if (id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", id_valid_o); end
        if (id_inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", id_inst_o); end
        if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", overflow_o); end
        $display("reset: valid=%0b inst=%h count=%0d ovf=%0b", id_valid_o, id_inst_o, count_o, overflow_o);
        rst = 1'b0;
    endtask

    task automatic test_free_flow();
        logic [31:0] pc;
        stall = ST_NONE;
        for (int i = 0; i < 3; i++) begin
            pc = 32'h100 + 32'(4 * i);
            drive(1'b1, pc);
            tick();
            checks += 4;
            if (id_pc_o !== pc) begin errors++; $display("FAIL flow_pc got=%h exp=%h", id_pc_o, pc); end
            if (id_inst_o !== (pc ^ 32'hA5A5_0000)) begin errors++; $display("FAIL flow_inst got=%h exp=%h", id_inst_o, pc ^ 32'hA5A5_0000); end
            if (id_valid_o !== 1'b1) begin errors++; $display("FAIL flow_valid got=%0b exp=1", id_valid_o); end
            if (count_o !== 3'd0) begin errors++; $display("FAIL flow_count got=%0d exp=0", count_o); end
            $display("flow: push pc=%h -> id_pc=%h count=%0d", pc, id_pc_o, count_o);
        end
        drive(1'b0, 32'h0);
        tick();
        checks++;
        if (id_valid_o !== 1'b0) begin errors++; $display("FAIL flow_bubble got=%0b exp=0", id_valid_o); end
        $display("flow: idle -> valid=%0b", id_valid_o);
    endtask

    task automatic test_if_stall();
        stall = ST_IF;
        drive(1'b1, 32'h60);
        tick();
        checks += 2;
        if (id_valid_o !== 1'b0) begin errors++; $display("FAIL ifstall_valid got=%0b exp=0", id_valid_o); end
        if (count_o !== 3'd0) begin errors++; $display("FAIL ifstall_count got=%0d exp=0", count_o); end
        $display("if_stall: pc=60 -> valid=%0b count=%0d", id_valid_o, count_o);
        drive(1'b0, 32'h0);
        stall = ST_NONE;
    endtask

    task automatic test_stall_fill();
        stall = ST_NONE;
        drive(1'b1, 32'h0C);
        tick();
        stall = ST_ID;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10 + 32'(4 * i));
            tick();
            checks += 2;
            if (count_o !== 3'(i + 1)) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", count_o, i + 1); end
            if (id_pc_o !== 32'h0C) begin errors++; $display("FAIL fill_hold got=%h exp=0000000c", id_pc_o); end
            $display("fill: push pc=%h count=%0d id_pc=%h", if_pc_i, count_o, id_pc_o);
        end
        drive(1'b0, 32'h0);
        tick();
        checks += 3;
        if (count_o !== 3'd4) begin errors++; $display("FAIL fill_full got=%0d exp=4", count_o); end
        if (stallreq_o !== 1'b1) begin errors++; $display("FAIL fill_stallreq got=%0b exp=1", stallreq_o); end
        if (id_valid_o !== 1'b1) begin errors++; $display("FAIL fill_valid_hold got=%0b exp=1", id_valid_o); end
        $display("fill: 5th stall cycle count=%0d stallreq=%0b", count_o, stallreq_o);
    endtask

    task automatic test_overflow();
        drive(1'b1, 32'h200);
        tick();
        checks += 3;
        if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0b exp=1", overflow_o); end
        if (count_o !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", count_o); end
        if (id_pc_o !== 32'h0C) begin errors++; $display("FAIL ovf_hold got=%h exp=0000000c", id_pc_o); end
        $display("overflow: push pc=200 -> ovf=%0b count=%0d", overflow_o, count_o);
        drive(1'b0, 32'h0);
    endtask

    task automatic test_drain();
        stall = ST_NONE;
        drive(1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks += 3;
            if (id_pc_o !== 32'h10 + 32'(4 * i)) begin errors++; $display("FAIL drain_pc got=%h exp=%h", id_pc_o, 32'h10 + 32'(4 * i)); end
            if (id_valid_o !== 1'b1) begin errors++; $display("FAIL drain_valid got=%0b exp=1", id_valid_o); end
            if (count_o !== 3'(3 - i)) begin errors++; $display("FAIL drain_count got=%0d exp=%0d", count_o, 3 - i); end
            $display("drain: id_pc=%h count=%0d", id_pc_o, count_o);
        end
        tick();
        checks++;
        if (id_valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty got=%0b exp=0", id_valid_o); end
        $display("drain: empty valid=%0b", id_valid_o);
    endtask

    task automatic test_flush();
        stall = ST_ID;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h30 + 32'(4 * i));
            tick();
        end
        checks++;
        if (count_o !== 3'd3) begin errors++; $display("FAIL flush_pre got=%0d exp=3", count_o); end
        flush = 1'b1;
        drive(1'b1, 32'h300);
        tick();
        flush = 1'b0;
        checks += 4;
        if (count_o !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count_o); end
        if (id_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b exp=0", id_valid_o); end
        if (id_pc_o !== 32'h0) begin errors++; $display("FAIL flush_pc got=%h exp=0", id_pc_o); end
        if (overflow_o !== 1'b1) begin errors++; $display("FAIL flush_ovf_kept got=%0b exp=1", overflow_o); end
        $display("flush: count=%0d valid=%0b pc=%h ovf=%0b", count_o, id_valid_o, id_pc_o, overflow_o);
        stall = ST_NONE;
        drive(1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (id_valid_o !== 1'b0 || id_pc_o === 32'h300) begin
                errors++; $display("FAIL flush_leak valid=%0b pc=%h exp valid=0", id_valid_o, id_pc_o);
            end
            $display("flush: after valid=%0b pc=%h", id_valid_o, id_pc_o);
        end
    endtask

    task automatic test_full_push_pop();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stall = ST_ID;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h40 + 32'(4 * i));
            tick();
        end
        checks++;
        if (count_o !== 3'd4) begin errors++; $display("FAIL pp_full got=%0d exp=4", count_o); end
        stall = ST_NONE;
        drive(1'b1, 32'h50);
        #1;
        checks++;
        if (stallreq_o !== 1'b0) begin errors++; $display("FAIL pp_stallreq got=%0b exp=0", stallreq_o); end
        tick();
        checks += 3;
        if (id_pc_o !== 32'h40) begin errors++; $display("FAIL pp_pc got=%h exp=00000040", id_pc_o); end
        if (count_o !== 3'd4) begin errors++; $display("FAIL pp_count got=%0d exp=4", count_o); end
        if (overflow_o !== 1'b0) begin errors++; $display("FAIL pp_ovf got=%0b exp=0", overflow_o); end
        $display("push_pop: id_pc=%h count=%0d ovf=%0b", id_pc_o, count_o, overflow_o);
        drive(1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks += 2;
            if (id_pc_o !== 32'h44 + 32'(4 * i)) begin errors++; $display("FAIL pp_order got=%h exp=%h", id_pc_o, 32'h44 + 32'(4 * i)); end
            if (count_o !== 3'(3 - i)) begin errors++; $display("FAIL pp_drain_count got=%0d exp=%0d", count_o, 3 - i); end
            $display("push_pop: drain id_pc=%h count=%0d", id_pc_o, count_o);
        end
    endtask

    initial begin
        test_reset();
        test_free_flow();
        test_if_stall();
        test_stall_fill();
        test_overflow();
        test_drain();
        test_flush();
        test_full_push_pop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
